// File: rtl/discriminator_seq.sv
// Two-layer fixed-point discriminator (9 -> 3 ReLU -> 1) evaluated serially
// through a single shared multiplier and one accumulator, one product per cycle.
`timescale 1ns/1ps
module discriminator_seq #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int N_INPUT     = 9,
    parameter int N_NEURON_L2 = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_INPUT*WIDTH-1:0]             a_flat,
    input  logic [N_INPUT*N_NEURON_L2*WIDTH-1:0] w_L2,
    input  logic [N_NEURON_L2*WIDTH-1:0]         b_L2,
    input  logic [N_NEURON_L2*WIDTH-1:0]         w_L3,
    input  logic [WIDTH-1:0]                     b_L3,
    output logic                                 busy,
    output logic                                 done,
    output logic [WIDTH-1:0]                     y
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_L2_MAC = 3'd2;
    localparam logic [2:0] S_L3_MAC = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a [N_INPUT];
    logic [WIDTH-1:0] r_h [N_NEURON_L2];
    logic [1:0]       r_n;
    logic [3:0]       r_k;
    logic [WIDTH-1:0] r_y;

    logic [WIDTH-1:0] w_a_in [N_INPUT];
    logic [WIDTH-1:0] w_w2   [N_INPUT*N_NEURON_L2];
    logic [WIDTH-1:0] w_b2   [N_NEURON_L2];
    logic [WIDTH-1:0] w_w3   [N_NEURON_L2];

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUT; gi++) begin : g_a
            assign w_a_in[gi] = a_flat[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < N_INPUT*N_NEURON_L2; gi++) begin : g_w2
            assign w_w2[gi] = w_L2[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < N_NEURON_L2; gi++) begin : g_l3
            assign w_b2[gi] = b_L2[gi*WIDTH +: WIDTH];
            assign w_w3[gi] = w_L3[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [4:0]         w_w2_idx;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [2*WIDTH-1:0] w_full;
    logic [WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]   w_sum;

    assign w_w2_idx = 5'(r_n) * 5'(N_INPUT) + 5'(r_k);

    // The one multiplier is steered between layer-2 and layer-3 operands.
    always_comb begin
        w_op_a = r_a[r_k];
        w_op_b = w_w2[w_w2_idx];
        if (r_state == S_L3_MAC) begin
            w_op_a = r_h[r_k[1:0]];
            w_op_b = w_w3[r_k[1:0]];
        end
    end

    // Sign-extended operands make the low 2*WIDTH bits an exact signed product;
    // taking bits [FRAC +: WIDTH] is the arithmetic shift followed by truncation.
    assign w_full = {{WIDTH{w_op_a[WIDTH-1]}}, w_op_a} * {{WIDTH{w_op_b[WIDTH-1]}}, w_op_b};
    assign w_prod = w_full[FRAC +: WIDTH];
    assign w_sum  = r_acc + w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_y     <= '0;
            for (int i = 0; i < N_INPUT; i++)     r_a[i] <= '0;
            for (int i = 0; i < N_NEURON_L2; i++) r_h[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int i = 0; i < N_INPUT; i++) r_a[i] <= w_a_in[i];
                    r_acc   <= w_b2[0];
                    r_n     <= '0;
                    r_k     <= '0;
                    r_state <= S_L2_MAC;
                end
                S_L2_MAC: begin
                    if (r_k == 4'(N_INPUT - 1)) begin
                        r_h[r_n] <= w_sum[WIDTH-1] ? '0 : w_sum;
                        r_k      <= '0;
                        if (r_n == 2'(N_NEURON_L2 - 1)) begin
                            r_acc   <= b_L3;
                            r_state <= S_L3_MAC;
                        end else begin
                            r_n   <= r_n + 2'd1;
                            r_acc <= w_b2[r_n + 2'd1];
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + 4'd1;
                    end
                end
                S_L3_MAC: begin
                    r_acc <= w_sum;
                    if (r_k == 4'(N_NEURON_L2 - 1)) begin
                        r_y     <= w_sum;
                        r_k     <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_OUT: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_OUT);
    assign y    = r_y;

endmodule
